// File: rtl/axi_lite_reg_slave_pkg.sv
// axi_pack: AXI4-Lite response/prot types and reg-slave FSM state enums.
// Shared by the interface, decoder and register slave.
package axi_pack;

  typedef logic [2:0] prot_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4_LITE: five-channel AXI4-Lite bundle with MASTER/SLAVE modports.
// Widths are set per instance and must match the attached slave.
interface AXI4_LITE
  import axi_pack::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  prot_t                 awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  prot_t                 arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport MASTER (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport SLAVE (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_reg_slave_decode.sv
// axi_lite_addr_decode: address/prot -> {word index, response}.
// Prot checking only with AXI_LITE_REG_SLAVE_PROT_CHECK_EN.
module axi_lite_addr_decode
  import axi_pack::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  prot_t                       i_prot,
  output logic [$clog2(NUM_REGS)-1:0] o_idx,
  output resp_t                       o_resp
);
  localparam int LO = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(NUM_REGS);
  localparam int HI = LO + IW;

  logic w_hi_set;
  logic w_unused;

  assign o_idx    = i_addr[LO +: IW];
  assign w_hi_set = |i_addr[ADDR_WIDTH-1:HI];

`ifdef AXI_LITE_REG_SLAVE_PROT_CHECK_EN
  assign w_unused = ^{i_addr[LO-1:0], i_prot[2:1]};

  // DECERR outranks the privilege check
  always_comb begin
    o_resp = RESP_OKAY;
    if (w_hi_set)
      o_resp = RESP_DECERR;
    else if (!i_prot[0])
      o_resp = RESP_SLVERR;
  end
`else
  assign w_unused = ^{i_addr[LO-1:0], i_prot};

  always_comb begin
    o_resp = RESP_OKAY;
    if (w_hi_set)
      o_resp = RESP_DECERR;
  end
`endif

endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register bank, one write + one read outstanding.
// Optional privilege check: define AXI_LITE_REG_SLAVE_PROT_CHECK_EN.
module axi_lite_reg_slave
  import axi_pack::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  AXI4_LITE.SLAVE                        axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IW         = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  wstate_t               r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  prot_t                 r_awprot;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [NUM_REGS-1:0]   r_wr_pulse;

  rstate_t               r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  resp_t                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_wr_go;
  logic [ADDR_WIDTH-1:0] w_waddr;
  prot_t                 w_wprot;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;
  logic [IW-1:0]         w_widx;
  resp_t                 w_wresp;
  logic [IW-1:0]         w_ridx;
  resp_t                 w_rresp;

  assign w_aw_hs = axi.awvalid && r_awready;
  assign w_w_hs  = axi.wvalid && r_wready;
  assign w_ar_hs = axi.arvalid && r_arready;

  // The half arriving on the completing edge is used directly, not latched
  assign w_waddr = (r_wstate == W_HAVE_AW) ? r_awaddr : axi.awaddr;
  assign w_wprot = (r_wstate == W_HAVE_AW) ? r_awprot : axi.awprot;
  assign w_wdata = (r_wstate == W_HAVE_W) ? r_wdata : axi.wdata;
  assign w_wstrb = (r_wstate == W_HAVE_W) ? r_wstrb : axi.wstrb;

  assign w_wr_go = ((r_wstate == W_IDLE) && w_aw_hs && w_w_hs) ||
                   ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                   ((r_wstate == W_HAVE_W) && w_aw_hs);

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wdec (
    .i_addr (w_waddr),
    .i_prot (w_wprot),
    .o_idx  (w_widx),
    .o_resp (w_wresp)
  );

  axi_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rdec (
    .i_addr (axi.araddr),
    .i_prot (axi.arprot),
    .o_idx  (w_ridx),
    .o_resp (w_rresp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_awprot   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_wr_go) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wresp;
        if (w_wresp == RESP_OKAY) begin
          r_wr_pulse[w_widx] <= 1'b1;
          for (int b = 0; b < STRB_WIDTH; b++)
            if (w_wstrb[b])
              r_regs[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end else begin
        unique case (r_wstate)
          W_IDLE: begin
            r_awready <= !w_aw_hs;
            r_wready  <= !w_w_hs;
            if (w_aw_hs) begin
              r_awaddr <= axi.awaddr;
              r_awprot <= axi.awprot;
              r_wstate <= W_HAVE_AW;
            end else if (w_w_hs) begin
              r_wdata  <= axi.wdata;
              r_wstrb  <= axi.wstrb;
              r_wstate <= W_HAVE_W;
            end
          end
          W_HAVE_AW: ;
          W_HAVE_W:  ;
          W_RESP: begin
            if (axi.bready) begin
              r_bvalid  <= 1'b0;
              r_awready <= 1'b1;
              r_wready  <= 1'b1;
              r_wstate  <= W_IDLE;
            end
          end
          default: r_wstate <= W_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= w_rresp;
            r_rdata   <= (w_rresp == RESP_OKAY) ? r_regs[w_ridx] : '0;
            r_rstate  <= R_RESP;
          end
        end
        R_RESP: begin
          if (axi.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bresp   = r_bresp;
  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rresp   = r_rresp;
  assign axi.rdata   = r_rdata;
  assign wr_pulse_o  = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule
